// File: rtl/rv32i_dmem_io_if.sv
// Data-side bus between the rv32i core, the memory/MMIO stage and its I/O ports.
// Carries the CPU load/store port, the output stream and the input-port strobe.
interface rv32i_dmem_io_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;

  // Core and surrounding I/O drive the bus.
  modport master (
    output mem_addr, mem_wdata, mem_we, out_ready, in_data, in_valid,
    input  mem_rdata, out_data, out_valid
  );

  // Memory stage answers it.
  modport slave (
    input  mem_addr, mem_wdata, mem_we, out_ready, in_data, in_valid,
    output mem_rdata, out_data, out_valid
  );
endinterface

// File: rtl/rv32i_dmem_io.sv
// Data memory stage for the rv32i core: word RAM plus an MMIO window holding an
// output FIFO, status register, free-running cycle counter and latched input port.
module rv32i_dmem_io #(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input logic             clk,
  input logic             reset,
  rv32i_dmem_io_if.slave  bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          overflow_reg;
  logic [31:0]   cycle_reg;
  logic [31:0]   in_latch_reg;

  logic          io_sel, reg_hit;
  logic [31:0]   off;
  logic [AW-1:0] ram_idx;
  logic          full, empty, push, pop, do_push, ovf_set, ovf_clr, cycle_wr;
  logic [31:0]   status;

  assign io_sel  = bus.mem_addr >= IO_BASE;
  assign off     = bus.mem_addr - IO_BASE;
  assign reg_hit = io_sel && (off[31:4] == 28'd0);
  assign ram_idx = bus.mem_addr[2 +: AW];

  assign full  = count_reg == (PW+1)'(FIFO_DEPTH);
  assign empty = count_reg == '0;

  assign push     = bus.mem_we && reg_hit && (off[3:2] == 2'd0);
  assign pop      = !empty && bus.out_ready;
  // A push into a full FIFO only lands if a pop frees the slot in the same cycle.
  assign do_push  = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign ovf_clr  = bus.mem_we && reg_hit && (off[3:2] == 2'd1) && bus.mem_wdata[2];
  assign cycle_wr = bus.mem_we && reg_hit && (off[3:2] == 2'd2);

  assign status = {16'h0, 8'(count_reg), 5'h0, overflow_reg, empty, full};

  assign bus.out_valid = !empty;
  assign bus.out_data  = fifo_mem[rd_ptr_reg];

  always_comb begin
    bus.mem_rdata = '0;
    if (!io_sel) begin
      bus.mem_rdata = ram[ram_idx];
    end else if (reg_hit) begin
      case (off[3:2])
        2'd1:    bus.mem_rdata = status;
        2'd2:    bus.mem_rdata = cycle_reg;
        2'd3:    bus.mem_rdata = in_latch_reg;
        default: bus.mem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && bus.mem_we && !io_sel) begin
      ram[ram_idx] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      fifo_mem[wr_ptr_reg] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      cycle_reg    <= '0;
      in_latch_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !pop)      count_reg <= count_reg + (PW+1)'(1);
      else if (pop && !do_push) count_reg <= count_reg - (PW+1)'(1);
      // Set beats clear when both occur together.
      if (ovf_set)      overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      cycle_reg <= cycle_wr ? bus.mem_wdata : cycle_reg + 32'd1;
      if (bus.in_valid) in_latch_reg <= bus.in_data;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, off[1:0]};
endmodule

// File: tb/tb_rv32i_dmem_io.sv
// Directed bench for rv32i_dmem_io: RAM, FIFO stream, overflow, cycle counter,
// input latch and mid-stream reset, each checked against hand-computed values.
module tb_rv32i_dmem_io;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX    = IO_BASE + 32'h0;
  localparam logic [31:0] A_STAT  = IO_BASE + 32'h4;
  localparam logic [31:0] A_CYC   = IO_BASE + 32'h8;
  localparam logic [31:0] A_IN    = IO_BASE + 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rv32i_dmem_io_if dif ();

  rv32i_dmem_io #(
    .RAM_WORDS  (256),
    .FIFO_DEPTH (8),
    .IO_BASE    (IO_BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    dif.mem_addr = addr;
    dif.mem_we   = 1'b0;
    #1;
    check(tag, dif.mem_rdata, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    dif.mem_addr  = addr;
    dif.mem_wdata = data;
    dif.mem_we    = 1'b1;
    tick();
    dif.mem_we    = 1'b0;
  endtask

  initial begin
    dif.mem_addr  = '0;
    dif.mem_wdata = '0;
    dif.mem_we    = 1'b0;
    dif.out_ready = 1'b0;
    dif.in_data   = '0;
    dif.in_valid  = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    rd("rst_cycle", A_CYC, 32'h0);
    check("rst_valid", {31'h0, dif.out_valid}, 32'h0);
    rd("rst_status", A_STAT, 32'h0000_0002);
    rd("rst_in", A_IN, 32'h0);
    tick();
    rd("cycle_inc", A_CYC, 32'h1);

    // 1. RAM store/load with address wrap and ignored low bits
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
    rd("ram_wrap", 32'h10 + 32'd1024, 32'hDEAD_BEEF);
    rd("ram_lowbits", 32'h13, 32'hDEAD_BEEF);

    // 2. FIFO stream
    wr(A_TX, 32'd1);
    check("fifo_lat_v", {31'h0, dif.out_valid}, 32'h1);
    check("fifo_lat_d", dif.out_data, 32'd1);
    wr(A_TX, 32'd2);
    wr(A_TX, 32'd3);
    rd("fifo_status3", A_STAT, 32'h0000_0300);
    tick();
    check("hold_stable", dif.out_data, 32'd1);
    rd("tx_reads_0", A_TX, 32'h0);
    dif.out_ready = 1'b1;
    #1;
    check("pop_1", dif.out_data, 32'd1);
    tick();
    check("pop_2", dif.out_data, 32'd2);
    tick();
    check("pop_3", dif.out_data, 32'd3);
    tick();
    check("drained", {31'h0, dif.out_valid}, 32'h0);
    dif.out_ready = 1'b0;

    // 3. Overflow, clear, and full push+pop
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h100 + 32'(i));
    rd("full_status", A_STAT, 32'h0000_0801);
    wr(A_TX, 32'h1FF);
    rd("ovf_status", A_STAT, 32'h0000_0805);
    check("ovf_head", dif.out_data, 32'h100);
    wr(A_STAT, 32'h4);
    rd("ovf_clear", A_STAT, 32'h0000_0801);
    dif.out_ready = 1'b1;
    wr(A_TX, 32'h200);
    rd("full_pushpop", A_STAT, 32'h0000_0801);
    for (int i = 1; i < 8; i++) begin
      check("order", dif.out_data, 32'h100 + 32'(i));
      tick();
    end
    check("order_last", dif.out_data, 32'h200);
    tick();
    check("ovf_drained", {31'h0, dif.out_valid}, 32'h0);
    dif.out_ready = 1'b0;

    // 4. Cycle counter load and wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd("cyc_load", A_CYC, 32'hFFFF_FFFE);
    tick();
    rd("cyc_max", A_CYC, 32'hFFFF_FFFF);
    tick();
    rd("cyc_wrap", A_CYC, 32'h0);

    // 5. Input latch
    dif.in_data  = 32'h55;
    dif.in_valid = 1'b1;
    tick();
    dif.in_data  = 32'hAA;
    dif.in_valid = 1'b0;
    tick();
    rd("in_latch", A_IN, 32'h55);
    rd("bad_offset", IO_BASE + 32'h10, 32'h0);

    // 6. Reset mid-stream with a coincident store
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h300 + 32'(i));
    rd("pre_rst_stat", A_STAT, 32'h0000_0400);
    reset         = 1'b0;
    dif.mem_addr  = 32'h10;
    dif.mem_wdata = 32'h1234_5678;
    dif.mem_we    = 1'b1;
    dif.out_ready = 1'b1;
    tick();
    dif.mem_we    = 1'b0;
    dif.out_ready = 1'b0;
    reset         = 1'b1;
    check("mid_rst_valid", {31'h0, dif.out_valid}, 32'h0);
    rd("mid_rst_stat", A_STAT, 32'h0000_0002);
    rd("mid_rst_cyc", A_CYC, 32'h0);
    rd("ram_kept", 32'h10, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
